// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: S1 registers the operands, S2 registers
// the recoded rows and the per-row +1 corrections that feed the 4:2 compressor tree.
module booth_pp_gen #(
  parameter  int WIDTH = 16,
  localparam int NPP   = WIDTH / 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       pp_valid,
  input  logic                       pp_ready,
  output logic [NPP*(WIDTH+1)-1:0]   pp_rows,
  output logic [NPP-1:0]             pp_neg
);

  localparam int RW = WIDTH + 1;

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [NPP*RW-1:0]    rows_q, rows_d;
  logic [NPP-1:0]       neg_q, neg_d;
  logic                 s1_adv, s2_adv;

  logic [WIDTH:0]       b_ext;
  logic [2:0]           trip;
  logic [RW-1:0]        mag;
  logic                 negd;
  logic [NPP*RW-1:0]    enc_rows;
  logic [NPP-1:0]       enc_neg;

  // b[-1] is the implicit zero below the LSB.
  assign b_ext = {b_q, 1'b0};

  always_comb begin
    enc_rows = '0;
    enc_neg  = '0;
    trip     = '0;
    mag      = '0;
    negd     = 1'b0;
    for (int i = 0; i < NPP; i++) begin
      trip = b_ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010: begin mag = {a_q[WIDTH-1], a_q}; negd = 1'b0; end
        3'b011:         begin mag = {a_q, 1'b0};         negd = 1'b0; end
        3'b100:         begin mag = {a_q, 1'b0};         negd = 1'b1; end
        3'b101, 3'b110: begin mag = {a_q[WIDTH-1], a_q}; negd = 1'b1; end
        default:        begin mag = '0;                  negd = 1'b0; end
      endcase
      // Negative digits use one's complement here; the +1 travels on pp_neg.
      enc_rows[i*RW +: RW] = negd ? ~mag : mag;
      enc_neg[i]           = negd;
    end
  end

  always_comb begin
    s2_adv     = !s2_valid_q || pp_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    s2_valid_d = s2_valid_q;
    rows_d     = rows_q;
    neg_d      = neg_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d = a;
        b_d = b;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rows_d = enc_rows;
        neg_d  = enc_neg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s2_valid_q <= 1'b0;
      rows_q     <= '0;
      neg_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      rows_q     <= rows_d;
      neg_q      <= neg_d;
    end
  end

  assign in_ready = s1_adv;
  assign pp_valid = s2_valid_q;
  assign pp_rows  = rows_q;
  assign pp_neg   = neg_q;

endmodule
